// File: rtl/trace_pkg.sv
// Shared types for the decision-trail stack: entry layout, command and FSM encodings.
package trace_pkg;

    localparam int unsigned TRACE_VAR_W = 9;
    localparam int unsigned ENTRY_W     = TRACE_VAR_W + 2;

    typedef struct packed {
        logic                   typ;     // 0 decide, 1 forced
        logic                   val;
        logic [TRACE_VAR_W-1:0] var_idx;
    } entry_t;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'd0,
        CMD_PUSH      = 2'd1,
        CMD_POP       = 2'd2,
        CMD_BACKTRACK = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNWIND = 2'd1,
        ST_REPUSH = 2'd2
    } state_e;

endpackage

// File: rtl/trace_stack_mem.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module trace_stack_mem #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 11,
    parameter int unsigned AW    = 7
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_stack.sv
// LIFO decision trail with push/pop and a multi-cycle backtrack that flips the last decision.
module trace_stack
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned VAR_W = 9,
    parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic             type_in,
    input  logic             val_in,
    input  logic [VAR_W-1:0] var_in,
    output logic             ready,
    output logic             out_valid,
    output logic             type_out,
    output logic             val_out,
    output logic [VAR_W-1:0] var_out,
    output logic             out_flip,
    output logic             top_valid,
    output logic             top_type,
    output logic             top_val,
    output logic [VAR_W-1:0] top_var,
    output logic [PTR_W-1:0] count,
    output logic [PTR_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             unsat
);

    localparam int unsigned E_W = VAR_W + 2;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] count_q, count_d, level_q, level_d;
    logic             out_valid_q, out_valid_d, out_flip_q, out_flip_d;
    logic [E_W-1:0]   out_entry_q, out_entry_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, unsat_q, unsat_d;
    logic [VAR_W:0]   saved_q, saved_d;   // {val, var} of the decision being flipped

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [E_W-1:0]   mem_wdata, top_entry;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == PTR_W'(DEPTH));

    trace_stack_mem #(.DEPTH(DEPTH), .WIDTH(E_W), .AW(AW)) u_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (AW'(count_q - PTR_W'(1))),
        .rdata_o (top_entry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_flip_q  <= 1'b0;
            out_entry_q <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            unsat_q     <= 1'b0;
            saved_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_flip_q  <= out_flip_d;
            out_entry_q <= out_entry_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            unsat_q     <= unsat_d;
            saved_q     <= saved_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        level_d     = level_q;
        out_valid_d = 1'b0;
        out_flip_d  = 1'b0;
        out_entry_d = out_entry_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        unsat_d     = unsat_q;
        saved_d     = saved_q;
        mem_we      = 1'b0;
        mem_waddr   = AW'(count_q);
        mem_wdata   = {type_in, val_in, var_in};

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_e'(cmd))
                        CMD_PUSH: begin
                            if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                mem_we  = 1'b1;
                                count_d = count_q + PTR_W'(1);
                                if (!type_in) level_d = level_q + PTR_W'(1);
                            end
                        end
                        CMD_POP: begin
                            if (is_empty) begin
                                udf_d = 1'b1;
                            end else begin
                                out_valid_d = 1'b1;
                                out_entry_d = top_entry;
                                count_d     = count_q - PTR_W'(1);
                                if (!top_entry[E_W-1]) level_d = level_q - PTR_W'(1);
                            end
                        end
                        CMD_BACKTRACK: begin
                            if (is_empty) unsat_d = 1'b1;
                            else          state_d = ST_UNWIND;
                        end
                        default: ;
                    endcase
                end
            end
            ST_UNWIND: begin
                if (is_empty) begin
                    unsat_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    out_entry_d = top_entry;
                    count_d     = count_q - PTR_W'(1);
                    if (!top_entry[E_W-1]) begin
                        level_d = level_q - PTR_W'(1);
                        saved_d = top_entry[VAR_W:0];
                        state_d = ST_REPUSH;
                    end else if (count_q == PTR_W'(1)) begin
                        // Last forced entry gone with no decision left to flip.
                        unsat_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REPUSH: begin
                mem_we      = 1'b1;
                mem_wdata   = {1'b1, ~saved_q[VAR_W], saved_q[VAR_W-1:0]};
                count_d     = count_q + PTR_W'(1);
                out_valid_d = 1'b1;
                out_flip_d  = 1'b1;
                out_entry_d = {1'b1, ~saved_q[VAR_W], saved_q[VAR_W-1:0]};
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready     = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_flip  = out_flip_q;
    assign type_out  = out_entry_q[E_W-1];
    assign val_out   = out_entry_q[VAR_W];
    assign var_out   = out_entry_q[VAR_W-1:0];
    assign top_valid = !is_empty;
    assign top_type  = top_entry[E_W-1];
    assign top_val   = top_entry[VAR_W];
    assign top_var   = top_entry[VAR_W-1:0];
    assign count     = count_q;
    assign level     = level_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign unsat     = unsat_q;

endmodule

// File: tb/tb_trace_stack.sv
// Directed bench for trace_stack (DEPTH=4): push/pop, backtrack with flip, unsat, over/underflow, reset.
module tb_trace_stack;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned VAR_W = TRACE_VAR_W;
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset, cmd_valid, type_in, val_in;
    logic [1:0]       cmd;
    logic [VAR_W-1:0] var_in;
    logic             ready, out_valid, type_out, val_out, out_flip;
    logic [VAR_W-1:0] var_out, top_var;
    logic             top_valid, top_type, top_val, empty, full;
    logic [PTR_W-1:0] count, level;
    logic             overflow, underflow, unsat;

    int n_cmp  = 0;
    int n_fail = 0;

    entry_t bt_exp [4];

    always #5 clock = ~clock;

    trace_stack #(.DEPTH(DEPTH), .VAR_W(VAR_W)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .type_in(type_in), .val_in(val_in), .var_in(var_in),
        .ready(ready), .out_valid(out_valid), .type_out(type_out), .val_out(val_out),
        .var_out(var_out), .out_flip(out_flip), .top_valid(top_valid), .top_type(top_type),
        .top_val(top_val), .top_var(top_var), .count(count), .level(level),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow), .unsat(unsat)
    );

    function automatic entry_t mk(input logic t, input logic v, input int x);
        entry_t e;
        e.typ     = t;
        e.val     = v;
        e.var_idx = VAR_W'(x);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input entry_t e, input logic flip);
        logic [ENTRY_W-1:0] obs_e;
        obs_e = {type_out, val_out, var_out};
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_entry"}, 32'(obs_e), 32'(e));
        check({tag, "_flip"}, 32'(out_flip), 32'(flip));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_cmd(input cmd_e c, input logic t, input logic v, input int x);
        cmd_valid = 1'b1;
        cmd       = c;
        type_in   = t;
        val_in    = v;
        var_in    = VAR_W'(x);
        tick();
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = CMD_NOP;
        type_in = 1'b0; val_in = 1'b0; var_in = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flip", 32'(out_flip), 32'd0);
        check("rst_out_entry", 32'({type_out, val_out, var_out}), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_top_valid", 32'(top_valid), 32'd0);
        check("rst_flags", 32'({overflow, underflow, unsat}), 32'd0);

        // Three pushes then POP
        do_cmd(CMD_PUSH, 1'b0, 1'b1, 5);
        check("push1_out_valid", 32'(out_valid), 32'd0);
        do_cmd(CMD_PUSH, 1'b1, 1'b0, 7);
        do_cmd(CMD_PUSH, 1'b1, 1'b1, 9);
        check("push3_count", 32'(count), 32'd3);
        check("push3_level", 32'(level), 32'd1);
        check("push3_top", 32'({top_type, top_val, top_var}), 32'(mk(1'b1, 1'b1, 9)));
        do_cmd(CMD_POP, 1'b0, 1'b0, 0);
        check_out("pop", mk(1'b1, 1'b1, 9), 1'b0);
        check("pop_count", 32'(count), 32'd2);
        check("pop_level", 32'(level), 32'd1);
        check("pop_top", 32'({top_type, top_val, top_var}), 32'(mk(1'b1, 1'b0, 7)));
        do_cmd(CMD_NOP, 1'b1, 1'b1, 3);
        check("nop_out_valid", 32'(out_valid), 32'd0);
        check("nop_count", 32'(count), 32'd2);

        // Backtrack over two forced entries; a PUSH held during unwind/repush is ignored
        do_reset();
        do_cmd(CMD_PUSH, 1'b0, 1'b1, 5);
        do_cmd(CMD_PUSH, 1'b1, 1'b0, 7);
        do_cmd(CMD_PUSH, 1'b1, 1'b1, 9);
        do_cmd(CMD_BACKTRACK, 1'b0, 1'b0, 0);
        check("bt0_ready", 32'(ready), 32'd0);
        check("bt0_out_valid", 32'(out_valid), 32'd0);
        bt_exp[0] = mk(1'b1, 1'b1, 9);
        bt_exp[1] = mk(1'b1, 1'b0, 7);
        bt_exp[2] = mk(1'b0, 1'b1, 5);
        bt_exp[3] = mk(1'b1, 1'b0, 5);
        cmd_valid = 1'b1; cmd = CMD_PUSH; type_in = 1'b1; val_in = 1'b1; var_in = VAR_W'(30);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("bt_emit%0d", i), bt_exp[i], i == 3);
            check($sformatf("bt_ready%0d", i), 32'(ready), 32'(i == 3));
        end
        cmd_valid = 1'b0; cmd = CMD_NOP;
        check("bt_count", 32'(count), 32'd1);
        check("bt_level", 32'(level), 32'd0);
        check("bt_top", 32'({top_type, top_val, top_var}), 32'(mk(1'b1, 1'b0, 5)));
        check("bt_flags", 32'({overflow, underflow, unsat}), 32'd0);
        tick();
        check("bt_after_valid", 32'(out_valid), 32'd0);

        // Only forced entries: backtrack ends in unsat
        do_reset();
        do_cmd(CMD_PUSH, 1'b1, 1'b0, 3);
        do_cmd(CMD_PUSH, 1'b1, 1'b1, 4);
        do_cmd(CMD_BACKTRACK, 1'b0, 1'b0, 0);
        tick();
        check_out("us_emit0", mk(1'b1, 1'b1, 4), 1'b0);
        check("us_ready0", 32'(ready), 32'd0);
        tick();
        check_out("us_emit1", mk(1'b1, 1'b0, 3), 1'b0);
        check("us_unsat", 32'(unsat), 32'd1);
        check("us_count", 32'(count), 32'd0);
        check("us_ready1", 32'(ready), 32'd1);
        tick();
        check("us_no_more", 32'(out_valid), 32'd0);
        do_cmd(CMD_BACKTRACK, 1'b0, 1'b0, 0);
        check("bt_empty_ready", 32'(ready), 32'd1);
        check("bt_empty_valid", 32'(out_valid), 32'd0);

        // Overflow then underflow at DEPTH=4
        do_reset();
        for (int i = 1; i <= 4; i++) do_cmd(CMD_PUSH, 1'b0, 1'b0, i);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd4);
        check("fill_ovf", 32'(overflow), 32'd0);
        do_cmd(CMD_PUSH, 1'b0, 1'b1, 5);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_level", 32'(level), 32'd4);
        for (int i = 4; i >= 1; i--) begin
            do_cmd(CMD_POP, 1'b0, 1'b0, 0);
            check_out($sformatf("drain%0d", i), mk(1'b0, 1'b0, i), 1'b0);
            check($sformatf("drain_level%0d", i), 32'(level), 32'(i - 1));
        end
        check("drain_udf", 32'(underflow), 32'd0);
        do_cmd(CMD_POP, 1'b0, 1'b0, 0);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_valid", 32'(out_valid), 32'd0);
        check("udf_count", 32'(count), 32'd0);
        check("udf_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-unwind, with a PUSH presented in the same cycle
        do_reset();
        check("rst_clears_flags", 32'({overflow, underflow, unsat}), 32'd0);
        do_cmd(CMD_PUSH, 1'b0, 1'b0, 6);
        do_cmd(CMD_PUSH, 1'b1, 1'b1, 8);
        do_cmd(CMD_BACKTRACK, 1'b0, 1'b0, 0);
        tick();
        check_out("mid_emit", mk(1'b1, 1'b1, 8), 1'b0);
        check("mid_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        cmd_valid = 1'b1; cmd = CMD_PUSH; type_in = 1'b0; val_in = 1'b0; var_in = VAR_W'(2);
        tick();
        reset = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        tick();
        check("mid_no_flip", 32'({out_valid, out_flip}), 32'd0);
        check("mid_no_repush", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
